// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, row sync, sweep debounce, 24-bit digit entry.
// Optional auto-repeat while a key is held: define KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_PERIOD     = 50000,
  parameter int unsigned DEBOUNCE_SWEEPS = 4,
  parameter int unsigned REPEAT_DELAY    = 125,
  parameter int unsigned REPEAT_RATE     = 25
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [23:0] data_out,
  output logic [3:0]  dot_index
);

  localparam int unsigned TW     = 20;
  localparam int unsigned CW     = 4;
  localparam logic [TW-1:0] TERM = TW'(SCAN_PERIOD - 1);
  localparam bit          DB_ONE = (DEBOUNCE_SWEEPS == 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      row_s1_q, row_s1_d;
  logic [3:0]      row_sync_q, row_sync_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      col_out_q, col_out_d;
  logic [15:0]     map_q, map_d;
  logic            sweep_done_q, sweep_done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [23:0]     data_q, data_d;
  logic [3:0]      dot_q, dot_d;

  logic            term_c;
  logic [4:0]      ones_c;
  logic [3:0]      key_idx_c;
  logic            single_c;
  logic            match_c;
  logic            db_last_c;
  logic            accept_c;
  logic [3:0]      accept_code_c;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int unsigned RW = 16;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;
  logic [RW-1:0]   rep_inc_c;
  logic [RW-1:0]   rep_lim_c;
  logic            rep_hit_c;

  // First repeat waits REPEAT_DELAY sweeps, later ones REPEAT_RATE sweeps
  always_comb begin
    rep_inc_c = rep_cnt_q + RW'(1);
    rep_lim_c = rep_phase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    rep_hit_c = (rep_inc_c >= rep_lim_c);
  end
`else
  logic [31:0] unused_repeat_params;
  assign unused_repeat_params = 32'(REPEAT_DELAY) ^ 32'(REPEAT_RATE);
`endif

  // Row synchroniser, column scan timer and sweep map capture
  always_comb begin
    row_s1_d     = row_in;
    row_sync_d   = row_s1_q;
    term_c       = (timer_q == TERM);
    timer_d      = term_c ? '0 : timer_q + TW'(1);
    col_d        = term_c ? col_q + 2'd1 : col_q;
    col_out_d    = ~(4'b0001 << col_d);
    sweep_done_d = term_c && (col_q == 2'd3);
    map_d        = map_q;
    if (term_c) begin
      for (int r = 0; r < 4; r++) begin
        map_d[{2'(r), col_q}] = ~row_sync_q[r];
      end
    end
  end

  // Sweep classification: SINGLE when exactly one map bit is set
  always_comb begin
    ones_c    = '0;
    key_idx_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_q[i]) begin
        ones_c    = ones_c + 5'd1;
        key_idx_c = 4'(i);
      end
    end
    single_c  = (ones_c == 5'd1);
    match_c   = single_c && (key_idx_c == cand_q);
    db_last_c = ((5'(cnt_q) + 5'd1) >= 5'(DEBOUNCE_SWEEPS));
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; MULTI and other-key sweeps count as release evidence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (sweep_done_q) begin
      case (state_q)
        S_IDLE: begin
          if (single_c) begin
            cand_d  = key_idx_c;
            cnt_d   = CW'(1);
            state_d = DB_ONE ? S_HELD : S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (match_c) begin
            cnt_d = cnt_q + CW'(1);
            if (db_last_c) state_d = S_HELD;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (!match_c) begin
            cnt_d   = DB_ONE ? '0 : CW'(1);
            state_d = DB_ONE ? S_IDLE : S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (match_c) begin
            state_d = S_HELD;
          end else if (db_last_c) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    if (sweep_done_q && (state_q == S_HELD) && match_c) begin
      rep_cnt_d   = rep_hit_c ? '0 : rep_inc_c;
      rep_phase_d = rep_phase_q | rep_hit_c;
    end
    if ((state_q != S_HELD) || (state_d != S_HELD)) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end
`endif
  end

  // FSM outputs: accept strobe and the code being accepted
  always_comb begin
    accept_c      = 1'b0;
    accept_code_c = cand_q;
    if (sweep_done_q) begin
      case (state_q)
        S_IDLE: begin
          if (single_c && DB_ONE) begin
            accept_c      = 1'b1;
            accept_code_c = key_idx_c;
          end
        end
        S_PRESS_DB: accept_c = match_c && db_last_c;
`ifdef KEYPAD_SCANNER_REPEAT_EN
        S_HELD:     accept_c = match_c && rep_hit_c;
`endif
        default:    accept_c = 1'b0;
      endcase
    end
  end

  // Accept action and entry register; clear wins over the shift
  always_comb begin
    key_valid_d = accept_c;
    key_code_d  = accept_c ? accept_code_c : key_code_q;
    data_d      = data_q;
    dot_d       = dot_q;
    if (clear) begin
      data_d = '0;
      dot_d  = '0;
    end else if (accept_c) begin
      data_d = {data_q[19:0], accept_code_c};
      dot_d  = (dot_q == 4'd5) ? 4'd0 : dot_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      row_s1_q     <= 4'hF;
      row_sync_q   <= 4'hF;
      timer_q      <= '0;
      col_q        <= '0;
      col_out_q    <= 4'b1110;
      map_q        <= '0;
      sweep_done_q <= 1'b0;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      data_q       <= '0;
      dot_q        <= '0;
    end else begin
      row_s1_q     <= row_s1_d;
      row_sync_q   <= row_sync_d;
      timer_q      <= timer_d;
      col_q        <= col_d;
      col_out_q    <= col_out_d;
      map_q        <= map_d;
      sweep_done_q <= sweep_done_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      data_q       <= data_d;
      dot_q        <= dot_d;
    end
  end

`ifdef KEYPAD_SCANNER_REPEAT_EN
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  assign col_out   = col_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign data_out  = data_q;
  assign dot_index = dot_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix keypad model.
module tb_keypad_scanner;

  localparam int unsigned SP    = 4;
  localparam int unsigned DB    = 4;
  localparam int unsigned SWEEP = 4 * SP;
  localparam int unsigned LAT   = (DB + 1) * 4 * SP + 3;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] data_out;
  logic [3:0]  dot_index;
  logic [15:0] pressed;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;
  logic [3:0] last_code = 4'h0;

  always #5 CLK = ~CLK;

  keypad_scanner #(
    .SCAN_PERIOD(SP), .DEBOUNCE_SWEEPS(DB), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .row_in(row_in), .col_out(col_out), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .data_out(data_out), .dot_index(dot_index)
  );

  // Key at row r, column c is bit r*4+c; it pulls row r low while column c is driven low
  assign row_in = ~{|(pressed[15:12] & ~col_out), |(pressed[11:8] & ~col_out),
                    |(pressed[7:4]   & ~col_out), |(pressed[3:0]  & ~col_out)};

  always @(negedge CLK) begin
    if (key_valid === 1'b1) begin
      pulses++;
      last_code = key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_pulse(input string tag, input int target);
    int waited;
    waited = 0;
    while (pulses < target && waited < int'(LAT) + 4) begin
      step(1);
      waited++;
    end
    chk({tag, "_timeout"}, 32'(pulses >= target), 32'd1);
  endtask

  task automatic press_key(input logic [3:0] k);
    int target;
    target  = pulses + 1;
    pressed = 16'h0001 << k;
    wait_pulse("press", target);
    chk("press_code", 32'(last_code), 32'(k));
    step(SWEEP);
    pressed = '0;
    step(6 * SWEEP);
  endtask

  initial begin
    logic [3:0] e;
    int base;
    RST_n   = 1'b0;
    clear   = 1'b0;
    pressed = '0;
    step(3);
    chk("reset_col", 32'(col_out), 32'hE);
    chk("reset_kv", 32'(key_valid), 32'd0);
    chk("reset_code", 32'(key_code), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_dot", 32'(dot_index), 32'd0);

    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      e = 4'b0001 << (((i + 1) / 4) % 4);
      e = ~e;
      chk("scan_col", 32'(col_out), 32'(e));
    end
    step(10 * SWEEP);
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_data", 32'(data_out), 32'd0);

    // Row 2 / column 1 -> code 9, only one pulse while held
    pressed = 16'h0001 << 9;
    wait_pulse("k9", 1);
    chk("k9_code", 32'(last_code), 32'h9);
    chk("k9_data", 32'(data_out), 32'h000009);
    chk("k9_dot", 32'(dot_index), 32'd1);
    step(10 * SWEEP);
    chk("k9_hold", 32'(pulses), 32'd1);
    pressed = '0;
    step(6 * SWEEP);

    // Seven digits: cursor wraps 5 -> 0 -> 1, oldest digit shifted out
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_data", 32'(data_out), 32'd0);
    chk("clr_dot", 32'(dot_index), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      press_key(4'(k));
      if (k == 5) chk("seq_dot5", 32'(dot_index), 32'd5);
      if (k == 6) begin
        chk("seq_data6", 32'(data_out), 32'h123456);
        chk("seq_dot6", 32'(dot_index), 32'd0);
      end
    end
    chk("seq_data7", 32'(data_out), 32'h234567);
    chk("seq_dot7", 32'(dot_index), 32'd1);
    chk("seq_pulses", 32'(pulses), 32'd8);

    // Two-sweep bounce is rejected, stable press of key 0 accepted once
    base    = pulses;
    pressed = 16'h0001;
    step(2 * SWEEP);
    pressed = '0;
    step(6 * SWEEP);
    chk("bounce", 32'(pulses), 32'(base));
    pressed = 16'h0001;
    wait_pulse("k0", base + 1);
    chk("k0_code", 32'(last_code), 32'h0);
    chk("k0_data", 32'(data_out), 32'h345670);
    chk("k0_dot", 32'(dot_index), 32'd2);
    step(2 * SWEEP);
    pressed = '0;
    step(SWEEP);
    pressed = 16'h0001;
    step(6 * SWEEP);
    chk("glitch", 32'(pulses), 32'(base + 1));
    pressed = '0;
    step(6 * SWEEP);

    // Keys 5 and A together are ignored; 5 alone is then accepted
    base    = pulses;
    pressed = 16'h0420;
    step(8 * SWEEP);
    chk("multi", 32'(pulses), 32'(base));
    pressed = 16'h0020;
    wait_pulse("k5", base + 1);
    chk("k5_code", 32'(last_code), 32'h5);
    chk("k5_data", 32'(data_out), 32'h456705);
    chk("k5_dot", 32'(dot_index), 32'd3);
    pressed = '0;
    step(6 * SWEEP);

    // Clear held through an accept: pulse still occurs, digit discarded
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    press_key(4'h1);
    press_key(4'h2);
    chk("pre_clr_data", 32'(data_out), 32'h000012);
    chk("pre_clr_dot", 32'(dot_index), 32'd2);
    base    = pulses;
    clear   = 1'b1;
    pressed = 16'h0001 << 3;
    wait_pulse("k3", base + 1);
    chk("clr_acc_code", 32'(last_code), 32'h3);
    chk("clr_acc_data", 32'(data_out), 32'd0);
    chk("clr_acc_dot", 32'(dot_index), 32'd0);
    clear   = 1'b0;
    pressed = '0;
    step(6 * SWEEP);
    chk("post_clr_data", 32'(data_out), 32'd0);
    press_key(4'hF);
    chk("kf_data", 32'(data_out), 32'h00000F);
    chk("kf_dot", 32'(dot_index), 32'd1);
    chk("total_pulses", 32'(pulses), 32'(base + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
